// File: rtl/stumps_pkg.sv
// Shared encodings and helpers for the STUMPS BIST sequencer.
package stumps_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RESET_CUT = 4'd1,
        GEN_DATA  = 4'd2,
        SHIFT     = 4'd3,
        CAPTURE   = 4'd4,
        SIGN      = 4'd5,
        FLUSH     = 4'd6,
        COMPARE   = 4'd7,
        DONE      = 4'd8
    } state_t;

    typedef struct packed {
        logic nbar_t;
        logic rst_out;
        logic prpg1_en;
        logic prpg2_en;
        logic misr1_en;
        logic misr2_en;
        logic busy;
        logic done;
    } ctrl_t;

    // Bits needed to hold 0..max_count, never less than one.
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            RESET_CUT: begin c.rst_out = 1'b1; c.nbar_t = 1'b1; c.busy = 1'b1; end
            GEN_DATA:  begin c.prpg1_en = 1'b1; c.busy = 1'b1; end
            SHIFT:     begin c.nbar_t = 1'b1; c.prpg2_en = 1'b1; c.misr2_en = 1'b1; c.busy = 1'b1; end
            CAPTURE:   c.busy = 1'b1;
            SIGN:      begin c.misr1_en = 1'b1; c.busy = 1'b1; end
            FLUSH:     begin c.nbar_t = 1'b1; c.misr2_en = 1'b1; c.busy = 1'b1; end
            COMPARE:   c.busy = 1'b1;
            DONE:      c.done = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bist_counter.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count flag.
module bist_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign tc = (count == limit);

endmodule

// File: rtl/stumps_bist_sequencer.sv
// STUMPS BIST sequencer: PRPG load, scan shift, capture, MISR compaction,
// final flush and golden-signature compare behind a start/busy/done handshake.
module stumps_bist_sequencer
    import stumps_pkg::*;
#(
    parameter int                   SHIFT_SIZE     = 8,
    parameter int                   NUM_ROUNDS     = 50,
    parameter int                   CAPTURE_CYCLES = 1,
    parameter int                   SIG_WIDTH      = 16,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG     = '0
) (
    input  logic                              clk,
    input  logic                              rstIn_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [SIG_WIDTH-1:0]              misrSig,
    output logic                              NbarT,
    output logic                              rstOut,
    output logic                              PRPG1_En,
    output logic                              PRPG2_En,
    output logic                              MISR1_En,
    output logic                              MISR2_En,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              fail,
    output logic [$clog2(NUM_ROUNDS+1)-1:0]   roundCount
);

    localparam int CW = cnt_width(((SHIFT_SIZE > CAPTURE_CYCLES) ? SHIFT_SIZE : CAPTURE_CYCLES) - 1);
    localparam int RW = $clog2(NUM_ROUNDS + 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFT_SIZE - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(CAPTURE_CYCLES - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(NUM_ROUNDS - 1);

    state_t        state, nxt;
    ctrl_t         ctrl;
    logic [CW-1:0] unused_sh_count, sh_limit;
    logic          sh_tc, sh_clr, sh_en;
    logic          rnd_tc, rnd_clr, rnd_en;

    // One counter times SHIFT, CAPTURE and FLUSH; it is zeroed on entry to each.
    assign sh_limit = (state == CAPTURE) ? CAP_LAST : SHIFT_LAST;
    assign sh_en    = (state == SHIFT) || (state == CAPTURE) || (state == FLUSH);
    assign sh_clr   = (state == RESET_CUT) || (state == GEN_DATA) || (state == SIGN) || (sh_en && sh_tc);
    assign rnd_clr  = (state == RESET_CUT);
    assign rnd_en   = (state == SIGN) && !abort;

    bist_counter #(.WIDTH(CW)) u_shift_cnt (
        .clk   (clk),
        .rst_n (rstIn_n),
        .clr   (sh_clr),
        .en    (sh_en),
        .limit (sh_limit),
        .count (unused_sh_count),
        .tc    (sh_tc)
    );

    bist_counter #(.WIDTH(RW)) u_round_cnt (
        .clk   (clk),
        .rst_n (rstIn_n),
        .clr   (rnd_clr),
        .en    (rnd_en),
        .limit (ROUND_LAST),
        .count (roundCount),
        .tc    (rnd_tc)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (start) nxt = RESET_CUT;
            RESET_CUT: nxt = GEN_DATA;
            GEN_DATA:  nxt = SHIFT;
            SHIFT:     if (sh_tc) nxt = CAPTURE;
            CAPTURE:   if (sh_tc) nxt = SIGN;
            SIGN:      nxt = rnd_tc ? FLUSH : GEN_DATA;
            FLUSH:     if (sh_tc) nxt = COMPARE;
            COMPARE:   nxt = DONE;
            DONE:      if (start) nxt = RESET_CUT;
            default:   nxt = IDLE;
        endcase
        if (ctrl.busy && abort)
            nxt = IDLE;
    end

    // Outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge clk or negedge rstIn_n) begin
        if (!rstIn_n) begin
            state <= IDLE;
            ctrl  <= '0;
            pass  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            state <= nxt;
            ctrl  <= decode(nxt);
            if (nxt == IDLE || nxt == RESET_CUT) begin
                pass <= 1'b0;
                fail <= 1'b0;
            end else if (state == COMPARE) begin
                pass <= (misrSig == GOLDEN_SIG);
                fail <= (misrSig != GOLDEN_SIG);
            end
        end
    end

    assign NbarT    = ctrl.nbar_t;
    assign rstOut   = ctrl.rst_out;
    assign PRPG1_En = ctrl.prpg1_en;
    assign PRPG2_En = ctrl.prpg2_en;
    assign MISR1_En = ctrl.misr1_en;
    assign MISR2_En = ctrl.misr2_en;
    assign busy     = ctrl.busy;
    assign done     = ctrl.done;

endmodule
